// File: rtl/spi_slave_core.sv
// SPI slave for modes 0-3, MSB/LSB first. rx_valid pulses the cycle after the 8th sample edge.
// One-byte TX buffer with valid/ready; an empty buffer at byte load sends 8'hFF and raises tx_underrun.
module spi_slave_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       lsbfe,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       tx_underrun,
   input  logic       err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   function automatic logic first_bit(input logic [7:0] b, input logic lsb);
      return lsb ? b[0] : b[7];
   endfunction

   function automatic logic [7:0] drop_bit(input logic [7:0] b, input logic lsb);
      return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
   endfunction

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_sync_vld;
   logic                   r_sclk_d;
   logic                   r_ss_d;
   logic                   r_ss_d_ok;

   state_t     r_state;
   logic       r_cpol;
   logic       r_cpha;
   logic       r_lsbfe;
   logic [2:0] r_cnt;
   logic [7:0] r_rx_sh;
   logic [7:0] r_tx_sh;
   logic [7:0] r_tx_buf;
   logic       r_tx_full;
   logic       r_miso;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_busy;
   logic       r_underrun;

   logic       w_sclk_s;
   logic       w_ss_s;
   logic       w_mosi_s;
   logic       w_rise;
   logic       w_fall;
   logic       w_lead;
   logic       w_trail;
   logic       w_sample;
   logic       w_shift;
   logic       w_ss_fall;
   logic       w_in_shift;
   logic       w_byte_end;
   logic       w_load;
   logic       w_tx_take;
   logic       w_tx_wr;
   logic       w_tx_adv;
   logic [7:0] w_load_byte;
   logic [7:0] w_rx_next;

   // r_sync_vld marks when the chains hold real samples rather than reset values,
   // so an ss held low through reset is not mistaken for a fresh falling edge.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_sclk_sync <= {SYNC_STAGES{cpol}};
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sync_vld  <= '0;
         r_sclk_d    <= cpol;
         r_ss_d      <= 1'b1;
         r_ss_d_ok   <= 1'b0;
      end else begin
         r_sclk_sync[0] <= sclk;
         r_ss_sync[0]   <= ss;
         r_mosi_sync[0] <= mosi;
         r_sync_vld[0]  <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_ss_sync[i]   <= r_ss_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
            r_sync_vld[i]  <= r_sync_vld[i-1];
         end
         r_sclk_d  <= w_sclk_s;
         r_ss_d    <= w_ss_s;
         r_ss_d_ok <= r_sync_vld[SYNC_STAGES-1];
      end
   end

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   assign w_rise   = w_sclk_s & ~r_sclk_d;
   assign w_fall   = ~w_sclk_s & r_sclk_d;
   assign w_lead   = r_cpol ? w_fall : w_rise;
   assign w_trail  = r_cpol ? w_rise : w_fall;
   assign w_sample = r_cpha ? w_trail : w_lead;
   assign w_shift  = r_cpha ? w_lead : w_trail;

   assign w_ss_fall  = r_ss_d_ok & r_ss_d & ~w_ss_s;
   assign w_in_shift = (r_state == ST_SHIFT) & ~w_ss_s;
   assign w_byte_end = w_in_shift & w_sample & (r_cnt == 3'd7);
   assign w_load     = ((r_state == ST_LOAD) & ~w_ss_s) | w_byte_end;

   // A load frees the buffer in the same cycle, so a concurrent write lands behind it.
   assign w_tx_take   = w_load & r_tx_full;
   assign tx_ready    = ~r_tx_full | w_tx_take;
   assign w_tx_wr     = tx_valid & tx_ready;
   assign w_load_byte = r_tx_full ? r_tx_buf : 8'hFF;

   assign w_rx_next = r_lsbfe ? {w_mosi_s, r_rx_sh[7:1]} : {r_rx_sh[6:0], w_mosi_s};

   // With cpha=0 the first bit is already out after the load, so the shift edge
   // that trails the 8th sample must not advance.
   assign w_tx_adv = w_in_shift & w_shift & (r_cpha | (r_cnt != 3'd0));

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state    <= ST_IDLE;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_lsbfe    <= 1'b0;
         r_cnt      <= 3'd0;
         r_rx_sh    <= 8'h00;
         r_tx_sh    <= 8'h00;
         r_tx_buf   <= 8'h00;
         r_tx_full  <= 1'b0;
         r_miso     <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_busy     <= ~w_ss_s;

         if (w_load && !r_tx_full) begin
            r_underrun <= 1'b1;
         end else if (err_clr) begin
            r_underrun <= 1'b0;
         end

         if (w_tx_wr) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
         end else if (w_tx_take) begin
            r_tx_full <= 1'b0;
         end

         if (w_load) begin
            if (r_cpha) begin
               r_tx_sh <= w_load_byte;
            end else begin
               r_tx_sh <= drop_bit(w_load_byte, r_lsbfe);
               r_miso  <= first_bit(w_load_byte, r_lsbfe);
            end
         end

         case (r_state)
            ST_IDLE: begin
               r_cpol  <= cpol;
               r_cpha  <= cpha;
               r_lsbfe <= lsbfe;
               r_cnt   <= 3'd0;
               r_rx_sh <= 8'h00;
               r_miso  <= 1'b0;
               if (w_ss_fall) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_ss_s) begin
                  r_state <= ST_IDLE;
                  r_miso  <= 1'b0;
               end else begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_ss_s) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 3'd0;
                  r_miso  <= 1'b0;
               end else begin
                  if (w_sample) begin
                     r_cnt   <= r_cnt + 3'd1;
                     r_rx_sh <= w_rx_next;
                     if (r_cnt == 3'd7) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                     end
                  end
                  if (w_tx_adv) begin
                     r_miso  <= first_bit(r_tx_sh, r_lsbfe);
                     r_tx_sh <= drop_bit(r_tx_sh, r_lsbfe);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign miso        = r_miso;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign busy        = r_busy;
   assign tx_underrun = r_underrun;

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of PCLK flops used to synchronise sclk, ss and mosi.
REQ-002 SHALL have port PCLK, input, 1, the single clock for all logic.
REQ-003 SHALL have port PRESET, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port cpol, input, 1, SCLK idle level.
REQ-005 SHALL have port cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL have port lsbfe, input, 1, 1 = LSB first, 0 = MSB first.
REQ-007 SHALL have port sclk, input, 1, serial clock from the SPI master, asynchronous to PCLK.
REQ-008 SHALL have port ss, input, 1, active-low slave select from the master.
REQ-009 SHALL have port mosi, input, 1, serial data from the master.
REQ-010 SHALL have port miso, output, 1, serial data to the master.
REQ-011 SHALL have port tx_data, input, 8, byte to transmit.
REQ-012 SHALL have port tx_valid, input, 1, tx_data is valid.
REQ-013 SHALL have port tx_ready, output, 1, TX holding buffer is empty.
REQ-014 SHALL have port rx_data, output, 8, last complete received byte.
REQ-015 SHALL have port rx_valid, output, 1, one-cycle pulse marking a new rx_data value.
REQ-016 SHALL have port busy, output, 1, high while ss is low (synchronised).
REQ-017 SHALL have port tx_underrun, output, 1, sticky flag: a byte started with an empty TX buffer.
REQ-018 SHALL have port err_clr, input, 1, clears tx_underrun.

Function
REQ-019 Sampling: sclk, ss and mosi SHALL each pass through SYNC_STAGES flops; all logic SHALL use only the synchronised copies.
REQ-020 SCLK edges: SHALL be detected as a change between consecutive synchronised samples. Leading edge = rising when cpol=0, falling when cpol=1.
- REQ-021 Sample and shift edges: the sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1. The shift edge is the other edge.
- REQ-022 Mode inputs: cpol, cpha and lsbfe SHALL be captured only in IDLE and held constant for the whole frame.
- REQ-023 States: the FSM SHALL have three states.
  - IDLE: ss_sync=1.
  - LOAD: one cycle after ss_sync falls.
  - SHIFT: active bits.
- REQ-024 IDLE->LOAD: SHALL occur on the ss_sync 1->0 transition.
- REQ-025 LOAD->SHIFT: SHALL occur unconditionally.
- REQ-026 Exit from LOAD or SHIFT: SHALL go to IDLE whenever ss_sync=1.
- REQ-027 Shift-register load (in LOAD, and in SHIFT after every 8th sample edge):
  - If the TX buffer is full, SHALL load the buffer and mark it empty.
  - Otherwise SHALL load 8'hFF and set tx_underrun.
- REQ-028 miso timing:
  - cpha=0: SHALL present the first bit in the cycle after the load.
  - cpha=1: SHALL present the first bit on the first shift edge.
  - Every subsequent bit SHALL change only on shift edges.
  - miso SHALL be 0 in IDLE.
- REQ-029 Bit order: the bit order of mosi and miso SHALL follow lsbfe. With lsbfe=1, bit 0 is first.
- REQ-030 Bit counter: a 3-bit counter SHALL increment on each sample edge. On the 8th edge it wraps 7->0.
- REQ-031 Byte completion: in the PCLK cycle after the 8th sample edge is detected, rx_data SHALL be updated and rx_valid SHALL be high for exactly 1 cycle.
- REQ-032 Back-to-back bytes: if ss stays low, the next byte SHALL follow without returning to IDLE, reloading per REQ-027.
- REQ-033 Mid-byte abort: ss_sync rising mid-byte SHALL discard the partial byte.
  - No rx_valid; rx_data unchanged.
  - Counter cleared.
  - Any shift-register contents discarded. A buffered TX byte not yet loaded is kept.
- REQ-034 TX handshake: tx_valid && tx_ready SHALL write tx_data into the buffer.
  - tx_ready SHALL deassert the next cycle.
  - A write and a load in the same cycle: the buffer SHALL take the new byte and the load SHALL take the old byte.
- REQ-035 tx_underrun: SHALL stay set until err_clr=1.
  - If err_clr and a new underrun occur in the same cycle, the set SHALL win.
- REQ-036 SCLK rate limit: SHALL operate correctly for sclk high and low phases of at least SYNC_STAGES+2 PCLK cycles. Behaviour is undefined for faster sclk.

Reset
REQ-037 While PRESET=1 at a PCLK rising edge, the block SHALL apply these values:
- state=IDLE.
- miso=0, rx_data=8'h00, rx_valid=0, busy=0.
- tx_ready=1 (buffer empty), tx_underrun=0.
- Counter=0; synchroniser flops set to sclk=cpol, ss=1, mosi=0.
REQ-038 A reset asserted mid-frame SHALL abort the frame without producing rx_valid. After reset is released, a new frame SHALL begin only on a fresh ss falling edge.

Verification
REQ-039 Mode 0, LSB first: tx 8'h3C preloaded; master sends 8'hAA. Required: rx_data=8'hAA with one rx_valid pulse; miso sequence 0,0,1,1,1,1,0,0.
REQ-040 Mode 3, MSB first: tx 8'hF0; master sends 8'hCC. Required: rx_data=8'hCC; miso sequence 1,1,1,1,0,0,0,0; sampling on rising sclk.
REQ-041 Two back-to-back bytes with ss held low and only 8'h55 buffered. Required: byte 1 returns 8'h55, byte 2 returns 8'hFF, tx_underrun=1; err_clr then clears it.
REQ-042 ss raised after 4 bits. Required: no rx_valid, rx_data unchanged; next full frame 8'h81 received correctly.
REQ-043 tx_valid written in the same cycle as a LOAD. Required: the old byte is shifted, the new byte is held, tx_ready=0.
REQ-044 PRESET asserted mid-byte. Required: all outputs return to their reset values within 1 cycle; no spurious rx_valid afterwards.
